uart_tx_periph: RTL
===================

// Module: uart_tx_periph
// PURPOSE
//  Memory-mapped UART transmitter, responder on the core data-memory bus (the ex-stage we/waddr/wdata/raddr/rdata path).
//  Program stores to its registers queue bytes in an internal FIFO; an 8N1 serialiser shifts them out on tx_o.
//  Lives in peripherals/, in parallel with ram; the top-level read mux selects rdata_o when rd_hit_o=1.
// PARAMETERS
//  BASE_ADDR    32'h1000_0000  register window base; window is 16 bytes (addr[31:4] == BASE_ADDR[31:4])
//  FIFO_DEPTH   8              TX FIFO entries; legal values 2, 4, 8
//  DEFAULT_DIV  16'd434        reset value of BAUDDIV (clk cycles per bit; 50 MHz / 115200)
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  we_i       in   1   bus write enable
//  waddr_i    in   32  bus write address
//  wdata_i    in   32  bus write data
//  raddr_i    in   32  bus read address
//  rdata_o    out  32  read data, combinational from raddr_i; 0 when no hit
//  rd_hit_o   out  1   raddr_i falls inside the register window
//  tx_o       out  1   serial output, registered, idle high
//  tx_busy_o  out  1   serialiser not IDLE, or FIFO not empty
// BEHAVIOUR
//  Register map (offset = addr[3:2]; addr[1:0] ignored; offset 3 reads 0, writes ignored):
//   0x0 TXDATA  W: push wdata_i[7:0] into FIFO. R: 0.
//   0x4 STATUS  R: [0] busy (state!=IDLE), [1] full, [2] empty, [3] overflow (sticky), [7:4] FIFO count; other bits 0.
//               W: writing 1 to bit3 clears overflow; all other bits read-only.
//   0x8 BAUDDIV R/W: [15:0] cycles per bit; a write of 0 stores 1. Upper bits read 0.
//  Writes take effect on the posedge where we_i=1 and waddr_i hits. Reads have zero latency (same cycle).
//  Reset: tx_o=1, FSM=IDLE, FIFO empty (count 0), overflow=0, BAUDDIV=DEFAULT_DIV, bit counter and baud counter 0.
//   rst has priority over every other event in the same cycle; reset mid-frame aborts the frame and tx_o is 1 from the next cycle.
//  FIFO: circular, wr/rd pointers wrap modulo FIFO_DEPTH; count is clog2(DEPTH)+1 bits wide.
//   A push is accepted if count<DEPTH, or if a pop happens in the same cycle; otherwise the byte is dropped and overflow is set.
//   Simultaneous push and pop: count unchanged, both pointers advance.
//  FSM states: IDLE, START, DATA, STOP; baud_cnt counts 0..div-1; bit_idx 0..7.
//   IDLE:  if FIFO non-empty, pop into shift reg, tx_o<=0, baud_cnt<=0 -> START.
//   START: when baud_cnt==div-1 -> DATA, tx_o<=shift[0].
//   DATA:  on each bit end, shift right and increment bit_idx; after bit 7 -> STOP, tx_o<=1.
//   STOP:  at bit end, if FIFO non-empty, pop and go directly to START (tx_o<=0, no idle gap); else -> IDLE.
//   Each bit holds exactly div cycles; a frame is 10*div cycles; bits go out LSB first.
//   div is sampled at every bit boundary, so a BAUDDIV write mid-frame takes effect from the next bit.
//  Latency: TXDATA write at edge N into an empty idle block -> pop at edge N+1 -> tx_o=0 from edge N+1.
//  Disjoint accesses: writes to addresses outside the window do nothing; reads outside the window give rdata_o=0 and rd_hit_o=0.
// TESTING
//  1 Reset: assert rst for 2 cycles -> tx_o=1; STATUS reads 0x0000_0004; BAUDDIV reads 434; tx_busy_o=0.
//  2 Single byte: BAUDDIV=4, then TXDATA=0x55 -> tx_o = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles (40 cycles total);
//    STATUS.busy=1 during the frame and 0 afterwards.
//  3 Burst: BAUDDIV=4, 10 TXDATA writes of 0x00..0x09 on consecutive cycles -> 0x09 dropped, STATUS.overflow=1;
//    bytes 0x00..0x08 are sent back-to-back, with each stop bit followed directly by a start bit.
//  4 Overflow clear: with overflow=1, write STATUS=0x8 -> STATUS[3]=0; FIFO contents and frame in progress unaffected.
//  5 Reset mid-frame: rst in cycle 15 of a frame with 3 bytes queued -> tx_o=1 next cycle, STATUS=0x4, no further start bits.
//  6 Decode and edge cases: write BASE+0x10 -> no effect; read BASE+0x10 -> rd_hit_o=0, rdata_o=0.
//    BAUDDIV=0 reads back 1 and gives 1-cycle bits. Push and pop in the same cycle with FIFO full -> count stays 8, no overflow.

Source files
------------

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers, TX FIFO and serialiser.
// Reads are combinational from raddr_i; all state changes on posedge clk.
module uart_tx_periph #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raddr_i,
    output logic [31:0] rdata_o,
    output logic        rd_hit_o,
    output logic        tx_o,
    output logic        tx_busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_reg, state_next;
    logic            tx_reg, tx_next;
    logic [15:0]     baud_reg, baud_next;
    logic [15:0]     cur_div_reg, cur_div_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic [15:0]     div_reg;
    logic            ovf_reg;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    logic            wr_hit, push, pop, accept, fifo_empty, fifo_full, bit_end;
    logic [1:0]      wr_off;
    logic            unused_bits;

    assign unused_bits = ^{waddr_i[1:0], raddr_i[1:0], wdata_i[31:16]};

    assign wr_hit     = (waddr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_off     = waddr_i[3:2];
    assign push       = we_i && wr_hit && (wr_off == 2'd0);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a byte when the serialiser pops in the same cycle.
    assign accept     = push && (!fifo_full || pop);
    assign bit_end    = (baud_reg == cur_div_reg - 16'd1);

    always_comb begin
        state_next   = state_reg;
        tx_next      = tx_reg;
        baud_next    = baud_reg + 16'd1;
        cur_div_next = cur_div_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                baud_next = baud_reg;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    tx_next      = 1'b0;
                    baud_next    = '0;
                    cur_div_next = div_reg;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next    = '0;
                    cur_div_next = div_reg;
                    tx_next      = shift_reg[0];
                    bit_next     = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next    = '0;
                    cur_div_next = div_reg;
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = shift_reg >> 1;
                        tx_next    = shift_reg[1];
                        bit_next   = bit_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next    = '0;
                    cur_div_next = div_reg;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            tx_reg      <= 1'b1;
            baud_reg    <= '0;
            cur_div_reg <= DEFAULT_DIV;
            bit_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            tx_reg      <= tx_next;
            baud_reg    <= baud_next;
            cur_div_reg <= cur_div_next;
            bit_reg     <= bit_next;
        end
    end

    // FIFO storage; the shift register doubles as the registered read port.
    always_ff @(posedge clk) begin
        if (accept)
            fifo_mem[wr_ptr_reg] <= wdata_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            shift_reg <= '0;
        else if (pop)
            shift_reg <= fifo_mem[rd_ptr_reg];
        else
            shift_reg <= shift_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            div_reg    <= DEFAULT_DIV;
        end else begin
            if (accept)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (accept && !pop)
                count_reg <= count_reg + CW'(1);
            else if (pop && !accept)
                count_reg <= count_reg - CW'(1);
            if (push && !accept)
                ovf_reg <= 1'b1;
            else if (we_i && wr_hit && (wr_off == 2'd1) && wdata_i[3])
                ovf_reg <= 1'b0;
            if (we_i && wr_hit && (wr_off == 2'd2))
                div_reg <= (wdata_i[15:0] == 16'd0) ? 16'd1 : wdata_i[15:0];
        end
    end

    always_comb begin
        rd_hit_o = (raddr_i[31:4] == BASE_ADDR[31:4]);
        rdata_o  = '0;
        if (rd_hit_o) begin
            case (raddr_i[3:2])
                2'd1:    rdata_o = {24'd0, 4'(count_reg), ovf_reg, fifo_empty, fifo_full,
                                    (state_reg != IDLE)};
                2'd2:    rdata_o = {16'd0, div_reg};
                default: rdata_o = '0;
            endcase
        end
    end

    assign tx_o      = tx_reg;
    assign tx_busy_o = (state_reg != IDLE) || !fifo_empty;
endmodule
